// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter that time-shares one external ripple-carry adder among NUM_REQ clients.
// Operands are held for SETTLE_CYCLES cycles before the adder output is registered and returned.
module adder_share_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int WIDTH         = 64,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  output logic [WIDTH-1:0]           add_in1,
  output logic [WIDTH-1:0]           add_in2,
  input  logic [WIDTH-1:0]           add_out,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [WIDTH-1:0]           rsp_sum
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  logic [1:0]       state_reg;
  logic [IDW-1:0]   last_reg;
  logic [IDW-1:0]   id_reg;
  logic [CW-1:0]    count_reg;
  logic [WIDTH-1:0] opa_reg;
  logic [WIDTH-1:0] opb_reg;
  logic             rsp_valid_reg;
  logic [IDW-1:0]   rsp_id_reg;
  logic [WIDTH-1:0] rsp_sum_reg;

  logic [WIDTH-1:0] slot_a [NUM_REQ];
  logic [WIDTH-1:0] slot_b [NUM_REQ];
  logic             any_valid;
  logic [IDW-1:0]   winner;
  logic [IDW-1:0]   cand;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slot
      assign slot_a[gi] = req_a[gi*WIDTH +: WIDTH];
      assign slot_b[gi] = req_b[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Walk from the farthest slot back to last+1 so the nearest valid one wins.
  always_comb begin
    any_valid = 1'b0;
    winner    = '0;
    cand      = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IDW'((int'(last_reg) + k) % NUM_REQ);
      if (req_valid[cand]) begin
        any_valid = 1'b1;
        winner    = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_reg == IDLE && any_valid) begin
      req_ready[winner] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      last_reg      <= IDW'(NUM_REQ - 1);
      id_reg        <= '0;
      count_reg     <= '0;
      opa_reg       <= '0;
      opb_reg       <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_id_reg    <= '0;
      rsp_sum_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (any_valid) begin
            opa_reg   <= slot_a[winner];
            opb_reg   <= slot_b[winner];
            last_reg  <= winner;
            id_reg    <= winner;
            count_reg <= '0;
            state_reg <= SETTLE;
          end
        end
        SETTLE: begin
          count_reg <= count_reg + CW'(1);
          if (count_reg == CW'(SETTLE_CYCLES - 1)) begin
            rsp_sum_reg   <= add_out;
            rsp_id_reg    <= id_reg;
            rsp_valid_reg <= 1'b1;
            state_reg     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Operand regs are only loaded on accept, so the adder stays quiet otherwise.
  assign add_in1   = opa_reg;
  assign add_in2   = opb_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_id    = rsp_id_reg;
  assign rsp_sum   = rsp_sum_reg;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Randomized self-checking bench for adder_share_arbiter with a round-robin/sum reference model.
// The shared adder itself is modelled here as a plain 64-bit add.
module tb_adder_share_arbiter;

  localparam int N = 4;
  localparam int W = 64;
  localparam int S = 2;

  logic           clk;
  logic           reset_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [W-1:0]   add_in1;
  logic [W-1:0]   add_in2;
  logic [W-1:0]   add_out;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_sum;

  logic [W-1:0] op_a [N];
  logic [W-1:0] op_b [N];

  int total_checks;
  int passed_checks;
  int cyc;
  int m_last;

  adder_share_arbiter #(.NUM_REQ(N), .WIDTH(W), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .add_in1(add_in1), .add_in2(add_in2), .add_out(add_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum)
  );

  assign add_out = add_in1 + add_in2;

  always_comb begin
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = op_a[i];
      req_b[i*W +: W] = op_b[i];
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_checks++;
    if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
    else passed_checks++;
  endtask

  // Reference rule: first valid requester strictly after the previous winner, wrapping.
  function automatic int rr_pick(input logic [N-1:0] mask, input int last);
    for (int k = 1; k <= N; k++) begin
      if (mask[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  // One full request/response transaction; mask must be nonzero.
  task automatic do_txn(input logic [N-1:0] mask, input int bp, input string tag,
                        output logic [N-1:0] gnt, output int gcyc);
    int w;
    int n;
    logic [W-1:0] ea, eb, esum;
    @(negedge clk);
    req_valid = mask;
    #1;
    check_val({tag, "_idle_rsp"}, 64'(rsp_valid), 64'd0);
    w = rr_pick(mask, m_last);
    gnt = req_ready;
    gcyc = cyc;
    check_val({tag, "_grant"}, 64'(req_ready), 64'd1 << w);
    ea = op_a[w];
    eb = op_b[w];
    esum = ea + eb;
    m_last = w;
    n = 0;
    while (1) begin
      @(negedge clk);
      #1;
      n++;
      if (rsp_valid) break;
      check_val({tag, "_settle_rdy"}, 64'(req_ready), 64'd0);
      check_val({tag, "_in1"}, add_in1, ea);
      check_val({tag, "_in2"}, add_in2, eb);
      if (n > 20) begin
        check_val({tag, "_timeout"}, 64'(rsp_valid), 64'd1);
        break;
      end
    end
    check_val({tag, "_latency"}, 64'(n), 64'(S + 1));
    check_val({tag, "_sum"}, rsp_sum, esum);
    check_val({tag, "_id"}, 64'(rsp_id), 64'(w));
    $display("txn %s: mask=%b winner=%0d a=%h b=%h sum=%h bp=%0d", tag, mask, w, ea, eb, rsp_sum, bp);
    if (bp > 0) begin
      rsp_ready = 1'b0;
      for (int i = 0; i < bp; i++) begin
        @(negedge clk);
        #1;
        check_val({tag, "_bp_valid"}, 64'(rsp_valid), 64'd1);
        check_val({tag, "_bp_sum"}, rsp_sum, esum);
        check_val({tag, "_bp_id"}, 64'(rsp_id), 64'(w));
        check_val({tag, "_bp_rdy"}, 64'(req_ready), 64'd0);
      end
      rsp_ready = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] gnt;
    int gcyc;
    int prev_gcyc;
    logic [N-1:0] mask;

    total_checks = 0;
    passed_checks = 0;
    cyc = 0;
    m_last = N - 1;
    reset_n = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
    end

    #12;
    check_val("rst_ready", 64'(req_ready), 64'd0);
    check_val("rst_valid", 64'(rsp_valid), 64'd0);
    check_val("rst_id", 64'(rsp_id), 64'd0);
    check_val("rst_sum", rsp_sum, 64'd0);
    check_val("rst_in1", add_in1, 64'd0);
    check_val("rst_in2", add_in2, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // T1 basic
    op_a[0] = 64'h0000123FAAAA0009;
    op_b[0] = 64'h0001123412341234;
    do_txn(4'b0001, 0, "t1", gnt, gcyc);
    check_val("t1_const_sum", rsp_sum, 64'h00012473BCDE123D);

    // T2 carry
    op_a[2] = 64'h000000000000FFFF;
    op_b[2] = 64'h000000000000FFFF;
    do_txn(4'b0100, 0, "t2", gnt, gcyc);
    check_val("t2_const_sum", rsp_sum, 64'h000000000001FFFE);

    // T3 wrap, then a normal result right after
    op_a[3] = 64'hFFFFFFFFFFFFFFFF;
    op_b[3] = 64'h0000000000000001;
    do_txn(4'b1000, 0, "t3", gnt, gcyc);
    check_val("t3_const_sum", rsp_sum, 64'd0);
    op_a[3] = 64'd5;
    op_b[3] = 64'd7;
    do_txn(4'b1000, 0, "t3b", gnt, gcyc);
    check_val("t3b_const_sum", rsp_sum, 64'd12);

    // T4 fairness with every requester held valid
    for (int i = 0; i < N; i++) begin
      op_a[i] = {$urandom, $urandom};
      op_b[i] = {$urandom, $urandom};
    end
    prev_gcyc = 0;
    for (int i = 0; i < 5; i++) begin
      do_txn(4'b1111, 0, "t4", gnt, gcyc);
      check_val("t4_order", 64'(gnt), 64'd1 << (i % N));
      if (i > 0) check_val("t4_gap", 64'(gcyc - prev_gcyc), 64'(S + 2));
      prev_gcyc = gcyc;
    end

    // T5 backpressure with other requesters still asking
    do_txn(4'b1111, 10, "t5", gnt, gcyc);

    // Randomized traffic
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < N; i++) begin
        op_a[i] = ($urandom_range(0, 3) == 0) ? 64'hFFFFFFFFFFFFFFFF : {$urandom, $urandom};
        op_b[i] = {$urandom, $urandom};
      end
      mask = 4'($urandom_range(0, 15));
      if (mask == 0) begin
        @(negedge clk);
        req_valid = '0;
        #1;
        check_val("rnd_nogrant", 64'(req_ready), 64'd0);
        $display("txn rnd: idle cycle, no request");
      end else begin
        do_txn(mask, $urandom_range(0, 3), "rnd", gnt, gcyc);
      end
    end

    // T6 reset during SETTLE discards the in-flight result
    op_a[1] = 64'h1234;
    op_b[1] = 64'h4321;
    @(negedge clk);
    req_valid = 4'b0010;
    #1;
    check_val("t6_grant", 64'(req_ready), 64'd1 << rr_pick(4'b0010, m_last));
    @(negedge clk);
    req_valid = '0;
    #3;
    reset_n = 1'b0;
    #1;
    check_val("t6_rst_ready", 64'(req_ready), 64'd0);
    check_val("t6_rst_valid", 64'(rsp_valid), 64'd0);
    check_val("t6_rst_sum", rsp_sum, 64'd0);
    check_val("t6_rst_id", 64'(rsp_id), 64'd0);
    check_val("t6_rst_in1", add_in1, 64'd0);
    check_val("t6_rst_in2", add_in2, 64'd0);
    $display("txn t6: reset asserted mid-settle");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    m_last = N - 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      check_val("t6_no_stale", 64'(rsp_valid), 64'd0);
    end
    do_txn(4'b1111, 0, "t6b", gnt, gcyc);
    check_val("t6_first_req0", 64'(gnt), 64'd1);

    @(negedge clk);
    req_valid = '0;
    #1;
    check_val("end_idle", 64'(rsp_valid), 64'd0);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
